// File: rtl/rca_share_arbiter_pkg.sv
// Shared types and defaults for the round-robin adder-sharing arbiter.
package rca_arb_pkg;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_W       = 16;
  localparam int unsigned DEF_ADD_LAT = 2;
  localparam int unsigned DEF_IDW     = 2;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned PERF_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef logic [DEF_W:0] sum_t;

endpackage

// File: rtl/rca_share_arbiter_if.sv
// Request/response bundle between operand clients and the shared adder arbiter.
interface rca_share_arbiter_if #(
  parameter int unsigned NREQ = rca_arb_pkg::DEF_NREQ,
  parameter int unsigned W    = rca_arb_pkg::DEF_W,
  parameter int unsigned IDW  = rca_arb_pkg::DEF_IDW
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W:0]        rsp_sum;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id
  );
endinterface

// File: rtl/rca_share_arbiter_adder.sv
// W-bit ripple-carry adder; sum MSB is the carry-out.
module rca_adder #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W:0]   sum
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    sum[W] = c[W];
  end

endmodule

// File: rtl/rca_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid request at or after ptr, modulo NREQ.
module rca_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            any
);

  int unsigned idx;

  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    idx = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!any && (j == idx) && req[j]) begin
          any = 1'b1;
          id  = IDW'(j);
        end
      end
    end
    if (any) gnt = NREQ'(1) << id;
  end

endmodule

// File: rtl/rca_share_arbiter.sv
// Round-robin arbiter sharing one multicycle ripple-carry adder among NREQ clients.
// Optional per-requester grant counters when RCA_ARB_PERF_EN is defined.
module rca_share_arbiter
  import rca_arb_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned ADD_LAT = DEF_ADD_LAT,
  parameter int unsigned IDW     = DEF_IDW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rca_share_arbiter_if.slave       arb,
  output logic                     busy
`ifdef RCA_ARB_PERF_EN
  ,
  input  logic                     cnt_clr,
  output logic [NREQ*PERF_W-1:0]   grant_cnt
`endif
);

  state_t           state, state_n;
  logic [IDW-1:0]   rr_ptr, id_q, pick_id;
  logic [NREQ-1:0]  pick_gnt, ready;
  logic             pick_any;
  logic [W-1:0]     a_q, b_q;
  logic [CNT_W-1:0] cnt;
  logic [W:0]       sum;
  logic             accept, exec_done, rsp_hs;

  rca_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (arb.req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .id  (pick_id),
    .any (pick_any)
  );

  // Adder only ever sees the held operand registers, so its output is stable while cnt runs down.
  rca_adder #(.W(W)) u_add (
    .a   (a_q),
    .b   (b_q),
    .cin (1'b0),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    exec_done = 1'b0;
    rsp_hs    = 1'b0;
    ready     = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          accept  = 1'b1;
          ready   = pick_gnt;
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          exec_done = 1'b1;
          state_n   = RESP;
        end
      end
      RESP: begin
        if (arb.rsp_ready) begin
          rsp_hs  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign arb.req_ready = ready;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= '0;
      cnt           <= '0;
      rr_ptr        <= '0;
      arb.rsp_valid <= 1'b0;
      arb.rsp_sum   <= '0;
      arb.rsp_id    <= '0;
    end else begin
      if (accept) begin
        a_q  <= arb.req_a[pick_id*W +: W];
        b_q  <= arb.req_b[pick_id*W +: W];
        id_q <= pick_id;
        cnt  <= CNT_W'(ADD_LAT - 1);
      end else if ((state == EXEC) && !exec_done) begin
        cnt <= cnt - 1'b1;
      end
      if (exec_done) begin
        arb.rsp_sum   <= sum;
        arb.rsp_id    <= id_q;
        arb.rsp_valid <= 1'b1;
      end
      if (rsp_hs) begin
        arb.rsp_valid <= 1'b0;
        rr_ptr        <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
      end
    end
  end

`ifdef RCA_ARB_PERF_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_perf
    logic [PERF_W-1:0] gcnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       gcnt <= '0;
      else if (cnt_clr)                 gcnt <= '0;
      else if (ready[i] && gcnt != '1)  gcnt <= gcnt + 1'b1;
    end
    assign grant_cnt[i*PERF_W +: PERF_W] = gcnt;
  end
`endif

endmodule

// File: tb/tb_rca_share_arbiter.sv
// Directed-vector bench for rca_share_arbiter (default 4 requesters, 16-bit, ADD_LAT=2).
module tb_rca_share_arbiter;
  import rca_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

`ifdef RCA_ARB_PERF_EN
  logic        cnt_clr = 1'b0;
  logic [63:0] grant_cnt;
`endif

  rca_share_arbiter_if #(.NREQ(4), .W(16), .IDW(2)) bus ();

  rca_share_arbiter #(.NREQ(4), .W(16), .ADD_LAT(2), .IDW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus),
    .busy  (busy)
`ifdef RCA_ARB_PERF_EN
    ,
    .cnt_clr   (cnt_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned r, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[r]       = 1'b1;
    bus.req_a[r*16 +: 16]  = a;
    bus.req_b[r*16 +: 16]  = b;
  endtask

  // One complete transaction with rsp_ready high; checks grant, latency, sum, id, return to idle.
  task automatic run_op(input string tag, input int unsigned r, input logic [15:0] a,
                        input logic [15:0] b, input logic [16:0] exp);
    int unsigned lat;
    set_req(r, a, b);
    #1;
    check({tag, "_grant"}, 32'(bus.req_ready), 32'(4'b0001 << r));
    tick();
    bus.req_valid[r] = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 3);
    check({tag, "_sum"}, 32'(bus.rsp_sum), 32'(exp));
    check({tag, "_id"}, 32'(bus.rsp_id), r);
    tick();
    check({tag, "_done"}, {30'd0, bus.rsp_valid, busy}, 0);
  endtask

  initial begin
    logic [16:0] exp_c [4];
    int unsigned order [5];
    int unsigned ng, cyc, last, seen, gid;
    logic [16:0] cur_exp;

    exp_c = '{17'h01011, 17'h02022, 17'h03033, 17'h04044};
    order = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset values
    repeat (2) tick();
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_rsp", {15'd0, bus.rsp_valid, busy, bus.rsp_sum[14:0]}, 0);
    check("rst_sum", 32'(bus.rsp_sum), 0);
    check("rst_id", 32'(bus.rsp_id), 0);
    rst_n = 1'b1;
    tick();

    run_op("single", 0, 16'h1234, 16'h0101, 17'h01335);
    run_op("ovf1", 2, 16'hFFFF, 16'h0001, 17'h10000);
    run_op("ovf2", 2, 16'hFFFF, 16'hFFFF, 17'h1FFFE);

    // Backpressure: response held for 10 cycles while another client waits
    bus.rsp_ready = 1'b0;
    set_req(3, 16'h4321, 16'h1234);
    #1;
    check("bp_grant", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid[3] = 1'b0;
    set_req(1, 16'h0001, 16'h0002);
    seen = 0;
    while (!bus.rsp_valid && seen < 20) begin
      tick();
      seen++;
    end
    for (int unsigned k = 0; k < 10; k++) begin
      check("bp_sum", 32'(bus.rsp_sum), 32'h05555);
      check("bp_hold", {26'd0, bus.rsp_valid, busy, bus.rsp_id, bus.req_ready[1], bus.req_ready[0]},
            {26'd0, 1'b1, 1'b1, 2'd3, 2'b00});
      tick();
    end
    bus.req_valid[1] = 1'b0;
    bus.rsp_ready    = 1'b1;
    tick();
    check("bp_release", 32'(bus.rsp_valid), 0);

    run_op("mid", 1, 16'h8000, 16'h7FFF, 17'h0FFFF);

    // Reset one cycle after accept discards the op and rewinds the pointer
    set_req(2, 16'h1111, 16'h2222);
    #1;
    check("rx_grant", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid[2] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rx_state", {29'd0, bus.rsp_valid, busy, |bus.req_ready}, 0);
    check("rx_sum", 32'(bus.rsp_sum), 0);
    check("rx_id", 32'(bus.rsp_id), 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int unsigned k = 0; k < 6; k++) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    check("rx_stale", seen, 0);

    // Contention: all four requesters held valid
    for (int unsigned r = 0; r < 4; r++)
      set_req(r, 16'(16'h1000 * (r + 1)), 16'(16'h0011 * (r + 1)));
    ng = 0; cyc = 0; last = 0; cur_exp = '0;
    while (ng < 5 && cyc < 60) begin
      #1;
      if (bus.req_ready != '0) begin
        check("ct_onehot", $countones(bus.req_ready), 1);
        gid = 0;
        for (int unsigned j = 0; j < 4; j++) if (bus.req_ready[j]) gid = j;
        check("ct_order", gid, order[ng]);
        if (ng > 0) check("ct_gap", cyc - last, 4);
        last = cyc;
        cur_exp = exp_c[gid];
        ng++;
      end
      if (bus.rsp_valid) check("ct_sum", 32'(bus.rsp_sum), 32'(cur_exp));
      tick();
      cyc++;
    end
    if (ng < 5) check("ct_timeout", ng, 5);
    bus.req_valid = '0;
    seen = 0;
    while (busy && seen < 20) begin
      tick();
      seen++;
    end
    check("ct_drain", 32'(busy), 0);

`ifdef RCA_ARB_PERF_EN
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("pf_clr", 32'(grant_cnt), 0);
    for (int unsigned k = 0; k < 5; k++)
      run_op("pf_op", 1, 16'(k), 16'h0001, 17'(k + 1));
    check("pf_cnt1", 32'(grant_cnt[31:16]), 5);
    check("pf_cnt0", 32'(grant_cnt[15:0]), 0);
    set_req(1, 16'h0002, 16'h0003);
    #1;
    check("pf_gr", 32'(bus.req_ready), 32'h2);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    bus.req_valid[1] = 1'b0;
    check("pf_clrwin", 32'(grant_cnt[31:16]), 0);
    seen = 0;
    while (busy && seen < 20) begin
      tick();
      seen++;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
